// File: rtl/seg_pkg.sv
// Shared constants for seven-segment display blocks: digit count and
// active-low glyph codes (seg[7:0] with the decimal point off).
package seg_pkg;

  localparam int unsigned SEG_DIGITS = 6;
  localparam int unsigned SEG_NIB_W  = 4;
  localparam int unsigned SEG_W      = 8;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  localparam logic [7:0] SEG_GLYPH_0 = 8'hC0;
  localparam logic [7:0] SEG_GLYPH_1 = 8'hF9;
  localparam logic [7:0] SEG_GLYPH_2 = 8'hA4;
  localparam logic [7:0] SEG_GLYPH_3 = 8'hB0;
  localparam logic [7:0] SEG_GLYPH_4 = 8'h99;
  localparam logic [7:0] SEG_GLYPH_5 = 8'h92;
  localparam logic [7:0] SEG_GLYPH_6 = 8'h82;
  localparam logic [7:0] SEG_GLYPH_7 = 8'hF8;
  localparam logic [7:0] SEG_GLYPH_8 = 8'h80;
  localparam logic [7:0] SEG_GLYPH_9 = 8'h90;
  localparam logic [7:0] SEG_GLYPH_A = 8'h88;
  localparam logic [7:0] SEG_GLYPH_B = 8'h83;
  localparam logic [7:0] SEG_GLYPH_C = 8'hC6;
  localparam logic [7:0] SEG_GLYPH_D = 8'hA1;
  localparam logic [7:0] SEG_GLYPH_E = 8'h86;
  localparam logic [7:0] SEG_GLYPH_F = 8'h8E;

  // Segment field g..a of a full glyph code.
  function automatic logic [6:0] seg_glyph7(input logic [7:0] glyph);
    return glyph[6:0];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [SEG_NIB_W-1:0] i_nibble,
  output logic [6:0]           o_seg_c
);

  always_comb begin
    o_seg_c = seg_glyph7(SEG_OFF);
    case (i_nibble)
      4'h0: o_seg_c = seg_glyph7(SEG_GLYPH_0);
      4'h1: o_seg_c = seg_glyph7(SEG_GLYPH_1);
      4'h2: o_seg_c = seg_glyph7(SEG_GLYPH_2);
      4'h3: o_seg_c = seg_glyph7(SEG_GLYPH_3);
      4'h4: o_seg_c = seg_glyph7(SEG_GLYPH_4);
      4'h5: o_seg_c = seg_glyph7(SEG_GLYPH_5);
      4'h6: o_seg_c = seg_glyph7(SEG_GLYPH_6);
      4'h7: o_seg_c = seg_glyph7(SEG_GLYPH_7);
      4'h8: o_seg_c = seg_glyph7(SEG_GLYPH_8);
      4'h9: o_seg_c = seg_glyph7(SEG_GLYPH_9);
      4'hA: o_seg_c = seg_glyph7(SEG_GLYPH_A);
      4'hB: o_seg_c = seg_glyph7(SEG_GLYPH_B);
      4'hC: o_seg_c = seg_glyph7(SEG_GLYPH_C);
      4'hD: o_seg_c = seg_glyph7(SEG_GLYPH_D);
      4'hE: o_seg_c = seg_glyph7(SEG_GLYPH_E);
      4'hF: o_seg_c = seg_glyph7(SEG_GLYPH_F);
    endcase
  end

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed seven-segment driver with per-digit scan and blanking slot.
// Optional leading-zero suppression when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_CNT = 250,
  parameter int unsigned DIGITS   = SEG_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEG_NIB_W*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        data_vld,
  output logic [DIGITS-1:0]           sel,
  output logic [SEG_W-1:0]            seg
);

  localparam int unsigned CNT_W = $clog2(SCAN_CNT);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]            r_cnt;
  logic [IDX_W-1:0]            r_idx;
  logic [SEG_NIB_W*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]           r_dp;

  logic                        w_term;
  logic [SEG_NIB_W-1:0]        w_nib;
  logic                        w_dp;
  logic                        w_blank_cur;
  logic [DIGITS-1:0]           w_blank;
  logic [6:0]                  w_glyph;

  assign w_term = (r_cnt == CNT_LAST);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit i blanks while it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    w_blank  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero   = run_zero & (r_disp[SEG_NIB_W*i +: SEG_NIB_W] == '0);
      w_blank[i] = run_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Select the nibble, dp and blank flag of the digit currently being scanned.
  always_comb begin
    w_nib       = r_disp[SEG_NIB_W-1:0];
    w_dp        = r_dp[0];
    w_blank_cur = w_blank[0];
    for (int i = 1; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp[SEG_NIB_W*i +: SEG_NIB_W];
        w_dp        = r_dp[i];
        w_blank_cur = w_blank[i];
      end
    end
  end

  seg_hex_decode u_decode (
    .i_nibble (w_nib),
    .o_seg_c  (w_glyph)
  );

  // Scanner, display register and output registers; sel/seg lag cnt/idx by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_disp <= '0;
      r_dp   <= '0;
      sel    <= '0;
      seg    <= SEG_OFF;
    end else begin
      if (w_term) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : IDX_W'(r_idx + 1'b1);
      end else begin
        r_cnt <= CNT_W'(r_cnt + 1'b1);
      end

      if (data_vld) begin
        r_disp <= data_in;
        r_dp   <= dp_in;
      end

      // The terminal cycle of each digit drives no select to avoid ghosting.
      sel <= w_term ? '0 : (DIGITS'(1) << r_idx);
      seg <= {~w_dp, (w_blank_cur ? SEG_BLANK : w_glyph)};
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Directed self-checking bench for seg_dynamic_scan with SCAN_CNT = 4.
module tb_seg_dynamic_scan;

  localparam int SCAN_CNT = 4;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // Expected glyph of a zero leading digit, and of digit 5 = 0 with dp lit.
  localparam logic [7:0] Z_HI  = LZ ? 8'hFF : 8'hC0;
  localparam logic [7:0] D5_DP = LZ ? 8'h7F : 8'h40;

  logic        clk;
  logic        rst;
  logic [23:0] data_in;
  logic [5:0]  dp_in;
  logic        data_vld;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  seg_dynamic_scan #(.SCAN_CNT(SCAN_CNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .data_vld (data_vld),
    .sel      (sel),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One digit slot: SCAN_CNT-1 selected cycles then one blank cycle.
  // An optional load is strobed on the terminal-count edge.
  task automatic digit(input int d, input logic [7:0] exp_seg, input bit ld,
                       input logic [23:0] d_in, input logic [5:0] dp);
    logic [5:0] exp_sel;
    exp_sel = 6'b000001 << d;
    for (int c = 0; c < SCAN_CNT - 1; c++) begin
      step();
      check($sformatf("d%0d c%0d sel", d, c), 8'(sel), 8'(exp_sel));
      check($sformatf("d%0d c%0d seg", d, c), seg, exp_seg);
    end
    if (ld) begin
      data_in  = d_in;
      dp_in    = dp;
      data_vld = 1'b1;
    end
    step();
    check($sformatf("d%0d blank sel", d), 8'(sel), 8'h00);
    check($sformatf("d%0d blank seg", d), seg, exp_seg);
    data_vld = 1'b0;
  endtask

  // Full frame; segs packed {digit5, ..., digit0}.
  task automatic frame(input logic [47:0] segs, input bit ld,
                       input logic [23:0] d_in, input logic [5:0] dp);
    for (int d = 0; d < 6; d++) begin
      digit(d, segs[8*d +: 8], ld && (d == 5), d_in, dp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    data_vld = 1'b0;
    data_in  = '0;
    dp_in    = '0;

    step();
    step();
    check("rst sel", 8'(sel), 8'h00);
    check("rst seg", seg, 8'hFF);

    // A strobe coincident with reset must be dropped.
    data_in  = 24'hFFFFFF;
    dp_in    = 6'h3F;
    data_vld = 1'b1;
    step();
    check("rst+vld sel", 8'(sel), 8'h00);
    check("rst+vld seg", seg, 8'hFF);
    rst      = 1'b0;
    data_vld = 1'b0;

    // Zero display, loading 543210 on the final terminal-count edge.
    frame({Z_HI, Z_HI, Z_HI, Z_HI, Z_HI, 8'hC0}, 1'b1, 24'h543210, 6'b000000);
    frame({8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 1'b1, 24'hFEDCBA, 6'b000000);
    frame({8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}, 1'b1, 24'h987654, 6'b000000);
    frame({8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99}, 1'b0, 24'h0, 6'b000000);

    // Load while digit 2 is selected: two edges later seg shows F with dp lit.
    digit(0, 8'h99, 1'b0, 24'h0, 6'b0);
    digit(1, 8'h92, 1'b0, 24'h0, 6'b0);
    step();
    check("mid d2 pre sel", 8'(sel), 8'h04);
    check("mid d2 pre seg", seg, 8'h82);
    data_in  = 24'h000F00;
    dp_in    = 6'b000100;
    data_vld = 1'b1;
    step();
    check("mid edge1 sel", 8'(sel), 8'h04);
    check("mid edge1 seg", seg, 8'h82);
    data_vld = 1'b0;
    step();
    check("mid edge2 sel", 8'(sel), 8'h04);
    check("mid edge2 seg", seg, 8'h0E);
    step();
    check("mid blank sel", 8'(sel), 8'h00);
    check("mid blank seg", seg, 8'h0E);
    digit(3, Z_HI, 1'b0, 24'h0, 6'b0);
    digit(4, Z_HI, 1'b0, 24'h0, 6'b0);
    digit(5, Z_HI, 1'b1, 24'h000120, 6'b100000);

    // Leading-zero behaviour and dp on an otherwise zero digit 5.
    frame({D5_DP, Z_HI, Z_HI, 8'hF9, 8'hA4, 8'hC0}, 1'b0, 24'h0, 6'b0);

    // Reset partway through digit 3.
    digit(0, 8'hC0, 1'b0, 24'h0, 6'b0);
    digit(1, 8'hA4, 1'b0, 24'h0, 6'b0);
    digit(2, 8'hF9, 1'b0, 24'h0, 6'b0);
    step();
    check("pre-rst d3 sel", 8'(sel), 8'h08);
    check("pre-rst d3 seg", seg, Z_HI);
    rst = 1'b1;
    step();
    check("mid rst sel", 8'(sel), 8'h00);
    check("mid rst seg", seg, 8'hFF);
    rst = 1'b0;
    digit(0, 8'hC0, 1'b0, 24'h0, 6'b0);
    digit(1, Z_HI, 1'b0, 24'h0, 6'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
